multicycle_control: RTL
=======================

# multicycle_control

Moore-style FSM that sequences the multicycle RISC-V datapath: one shared memory port, one ALU, IR/A/B/ALUOut/OLD_PC registers. It issues per-state datapath enables and mux selects, waits on the memory handshake, and signals instruction retirement. It replaces the single-cycle combinational decoder when the core runs in multicycle mode. Control signal names and ALUOp encodings match the single-cycle control (ALUOp 00=add, 01=sub, 10=funct decode).

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  start/continue fetching; sampled in IDLE and at retirement
- opcode  in  7  IR[6:0]; stable from DECODE until retirement
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR and OLD_PC load enable
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_src_a  out  2  00=PC, 01=A, 10=OLD_PC
- alu_src_b  out  2  00=B, 01=const 4, 10=immediate
- alu_op  out  2  00=add, 01=sub, 10=funct decode
- pc_src  out  1  0=ALU result, 1=ALUOut
- branch  out  1  high in BRANCH state
- jump  out  1  high in JUMP state; register write-back selects OLD_PC+4
- mem_2_reg  out  1  write-back select: 1=memory data
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle retirement pulse
- illegal  out  1  one-cycle pulse for an unsupported opcode
- instr_cnt  out  32  retired-instruction counter, wraps

## Operation
- Opcodes: R 0110011, I 0010011, BEQ 1100011, JAL 1101111, LOAD 0000011, STORE 0100011.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when enable=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00, so ALUOut = OLD_PC+imm.
  - Next state by opcode: R→EXEC_R, I→EXEC_I, LOAD/STORE→MEM_ADDR, BEQ→BRANCH, JAL→JUMP.
  - Any other opcode: illegal=1 and instr_done=1, then retire.
- EXEC_R: a=01, b=00, alu_op=10 → ALU_WB.
- EXEC_I: a=01, b=10, alu_op=10 → ALU_WB.
- ALU_WB: reg_write=1, mem_2_reg=0, instr_done=1 → retire.
- MEM_ADDR: a=01, b=10, alu_op=00. Go to MEM_RD if LOAD, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_2_reg=1, instr_done=1 → retire.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, retire. Otherwise hold.
- BRANCH: a=01, b=00, alu_op=01, branch=1, pc_src=1, pc_write=zero (combinational), instr_done=1 → retire.
- JUMP: pc_write=1, pc_src=1, jump=1, reg_write=1, instr_done=1 → retire.
- Retire: next state is FETCH if enable=1, else IDLE.
- mem_read/mem_write stay asserted, with stable i_or_d, until the mem_ready cycle. They are never both high.
- instr_cnt increments on every instr_done, including illegal. It wraps 0xFFFFFFFF→0.

## Timing
- State and instr_cnt are registered. Outputs decode combinationally from state, plus opcode/zero/mem_ready where noted above.
- arst_n low: state=IDLE and instr_cnt=0 immediately, asynchronously. All outputs go 0 in the same instant.
- Reset asserted mid-instruction aborts it with no write or retirement. Release is synchronous to the first clk edge.
- Cycles per instruction with mem_ready tied 1 (FETCH through retirement, inclusive):
  - R/I: 4
  - LOAD: 5
  - STORE: 4
  - BEQ: 3
  - JAL: 3
  - illegal: 2
- Each memory wait cycle adds one cycle.
- Back-to-back: FETCH of the next instruction starts the cycle after instr_done.

## Test plan
- Reset: hold arst_n=0, then release with enable=0 → stays IDLE; all outputs 0; instr_cnt=0.
- enable=1, mem_ready=1, opcode=0110011 → FETCH(ir_write=1, pc_write=1), DECODE, EXEC_R(alu_op=10), ALU_WB(reg_write=1, instr_done=1); instr_cnt=1.
- LOAD with mem_ready=0 for 3 cycles in both FETCH and MEM_RD → mem_read held; total 11 cycles; MEM_WB has mem_2_reg=1.
- BEQ twice, zero=1 then zero=0 → pc_write=1 then pc_write=0 in BRANCH; both retire in 3 cycles.
- opcode=1111111 → illegal=1 and instr_done=1 in DECODE; next state FETCH; STORE afterwards gives mem_write=1, i_or_d=1 with reg_write=0.
- arst_n pulsed low during MEM_WR → IDLE, no instr_done, count unchanged. Separately, preload instr_cnt=0xFFFFFFFF and retire one instruction → count wraps to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Control bundle between the multicycle FSM and the datapath.
//   master : the control FSM (samples enable/opcode/zero/mem_ready,
//            drives every enable, mux select and status pulse)
//   slave  : the datapath / memory side (the mirror image)
//   Signals:
//     enable, opcode[6:0], zero, mem_ready            -> FSM
//     pc_write, ir_write, i_or_d, mem_read, mem_write,
//     alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0],
//     pc_src, branch, jump, mem_2_reg, reg_write,
//     instr_done, illegal, instr_cnt[31:0]            <- FSM
interface multicycle_control_if;
    logic        enable;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        pc_src;
    logic        branch;
    logic        jump;
    logic        mem_2_reg;
    logic        reg_write;
    logic        instr_done;
    logic        illegal;
    logic [31:0] instr_cnt;

    modport master (
        input  enable, opcode, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, pc_src, branch, jump,
               mem_2_reg, reg_write, instr_done, illegal, instr_cnt
    );

    modport slave (
        output enable, opcode, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, pc_src, branch, jump,
               mem_2_reg, reg_write, instr_done, illegal, instr_cnt
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style sequencer for the multicycle RISC-V datapath (shared memory
//   port, single ALU, IR/A/B/ALUOut/OLD_PC registers). Issues per-state
//   enables and mux selects, waits on the memory handshake and pulses
//   instr_done on retirement. instr_cnt counts retirements (wrapping).
//   Ports:
//     clk     - rising-edge clock
//     arst_n  - asynchronous active-low reset (state -> IDLE, count -> 0)
//     ctl     - multicycle_control_if.master control bundle
module multicycle_control (
    input  logic                 clk,
    input  logic                 arst_n,
    multicycle_control_if.master ctl
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_ALU_WB   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    logic [3:0]  state_q, state_d;
    logic [3:0]  retire_state;
    logic [31:0] cnt_q;

    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       pc_src, branch, jump, mem_2_reg, reg_write;
    logic       instr_done, illegal;

    // enable is re-sampled at every retirement so the core can be paused
    // between instructions.
    assign retire_state = ctl.enable ? S_FETCH : S_IDLE;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        mem_2_reg  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl.enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only latched
                // together with IR on the cycle memory delivers the word.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = ctl.mem_ready;
                ir_write  = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= OLD_PC + imm: branch/jump target, computed
                // speculatively for every opcode.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (ctl.opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BEQ:             state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = retire_state;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (ctl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (ctl.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_2_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (ctl.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = retire_state;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                branch     = 1'b1;
                pc_src     = 1'b1;
                pc_write   = ctl.zero;
                instr_done = 1'b1;
                state_d    = retire_state;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                jump       = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign ctl.pc_write   = pc_write;
    assign ctl.ir_write   = ir_write;
    assign ctl.i_or_d     = i_or_d;
    assign ctl.mem_read   = mem_read;
    assign ctl.mem_write  = mem_write;
    assign ctl.alu_src_a  = alu_src_a;
    assign ctl.alu_src_b  = alu_src_b;
    assign ctl.alu_op     = alu_op;
    assign ctl.pc_src     = pc_src;
    assign ctl.branch     = branch;
    assign ctl.jump       = jump;
    assign ctl.mem_2_reg  = mem_2_reg;
    assign ctl.reg_write  = reg_write;
    assign ctl.instr_done = instr_done;
    assign ctl.illegal    = illegal;
    assign ctl.instr_cnt  = cnt_q;

endmodule
